// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-side types for the RV32I front end.
//   fetch_state_t : fetch controller FSM states
//   fetch_entry_t : one fetch buffer slot (PC tag, instruction, filled flag)
package fetch_ctrl_pkg;

  localparam int unsigned FETCH_NB_ADDR = 32;
  localparam int unsigned FETCH_NB_WORD = 32;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_NB_ADDR-1:0] pc;
    logic [FETCH_NB_WORD-1:0] instr;
    logic                     filled;
  } fetch_entry_t;

  // RV32I targets must be word aligned
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_buffer.sv
// fetch_buffer: MAX_OUT-entry circular buffer of fetch slots.
// A slot is allocated (with its PC) when a request is granted, filled in
// request order as responses return, and popped from the head by decode.
// Ports:
//   i_clock, i_reset       clock, synchronous active-low reset
//   i_alloc, i_alloc_pc    allocate tail slot tagged with PC
//   i_fill, i_fill_data    fill oldest unfilled slot
//   i_pop                  retire head slot (only if it is filled)
//   i_clear                drop every slot
//   o_count                allocated slots
//   o_unfilled             allocated slots still awaiting a response
//   o_head_valid           head slot allocated and filled
//   o_head_pc, o_head_instr  head slot contents
module fetch_buffer
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned NB_ADDR = 32,
  parameter int unsigned NB_WORD = 32,
  parameter int unsigned MAX_OUT = 2,
  parameter int unsigned PW      = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1,
  parameter int unsigned CW      = PW + 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_alloc,
  input  logic [NB_ADDR-1:0] i_alloc_pc,
  input  logic               i_fill,
  input  logic [NB_WORD-1:0] i_fill_data,
  input  logic               i_pop,
  input  logic               i_clear,
  output logic [CW-1:0]      o_count,
  output logic [CW-1:0]      o_unfilled,
  output logic               o_head_valid,
  output logic [NB_ADDR-1:0] o_head_pc,
  output logic [NB_WORD-1:0] o_head_instr
);

  fetch_entry_t entries_q [MAX_OUT];
  fetch_entry_t entries_d [MAX_OUT];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [CW-1:0] head_q, head_d;
  logic [CW-1:0] tail_q, tail_d;
  logic [CW-1:0] fill_q, fill_d;

  logic [PW-1:0] head_idx, tail_idx, fill_idx;
  logic [CW-1:0] count;
  logic          head_valid;

  always_comb begin
    head_idx   = head_q[PW-1:0];
    tail_idx   = tail_q[PW-1:0];
    fill_idx   = fill_q[PW-1:0];
    count      = tail_q - head_q;
    head_valid = (count != '0) && entries_q[head_idx].filled;

    o_count      = count;
    o_unfilled   = tail_q - fill_q;
    o_head_valid = head_valid;
    o_head_pc    = entries_q[head_idx].pc;
    o_head_instr = entries_q[head_idx].instr;
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    fill_d    = fill_q;

    if (i_clear) begin
      head_d = '0;
      tail_d = '0;
      fill_d = '0;
      for (int unsigned i = 0; i < MAX_OUT; i++) begin
        entries_d[i].filled = 1'b0;
      end
    end else begin
      // fill slot always lies strictly between head and tail, so fill,
      // pop and alloc never touch the same slot in one cycle
      if (i_fill && (fill_q != tail_q)) begin
        entries_d[fill_idx].instr  = i_fill_data;
        entries_d[fill_idx].filled = 1'b1;
        fill_d                     = fill_q + CW'(1);
      end
      if (i_pop && head_valid) begin
        head_d = head_q + CW'(1);
      end
      if (i_alloc && (count != CW'(MAX_OUT))) begin
        entries_d[tail_idx].pc     = i_alloc_pc;
        entries_d[tail_idx].instr  = '0;
        entries_d[tail_idx].filled = 1'b0;
        tail_d                     = tail_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      for (int unsigned i = 0; i < MAX_OUT; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      fill_q    <= fill_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC and sequences in-order instruction fetch.
// Issues requests to instruction memory, tags responses with their PC in
// fetch_buffer, applies redirects (squashing in-flight old-path fetches via
// a drop counter) and traps misaligned redirect targets to TRAP_VECTOR.
// Ports:
//   i_clock, i_reset                 clock, synchronous active-low reset
//   i_redirect, i_redirect_addr      redirect request and target
//   o_flush                          squash younger IF/ID state this cycle
//   o_exc_misaligned, o_exc_addr     misaligned-target pulse and address
//   o_imem_req, o_imem_addr, i_imem_gnt           request channel
//   i_imem_rvalid, i_imem_rdata                    in-order response channel
//   o_instr_valid, o_instr, o_instr_pc, i_instr_ready  decode interface
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned         NB_ADDR     = 32,
  parameter int unsigned         NB_WORD     = 32,
  parameter logic [NB_ADDR-1:0]  RESET_PC    = 32'h0000_0000,
  parameter logic [NB_ADDR-1:0]  TRAP_VECTOR = 32'h0000_0010,
  parameter int unsigned         MAX_OUT     = 2
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_redirect,
  input  logic [NB_ADDR-1:0] i_redirect_addr,
  output logic               o_flush,
  output logic               o_exc_misaligned,
  output logic [NB_ADDR-1:0] o_exc_addr,
  output logic               o_imem_req,
  output logic [NB_ADDR-1:0] o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic               i_imem_rvalid,
  input  logic [NB_WORD-1:0] i_imem_rdata,
  output logic               o_instr_valid,
  output logic [NB_WORD-1:0] o_instr,
  output logic [NB_ADDR-1:0] o_instr_pc,
  input  logic               i_instr_ready
);

  localparam int unsigned   PW      = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned   CW      = PW + 1;
  localparam logic [CW-1:0] CREDITS = CW'(MAX_OUT);

  fetch_state_t       state_q, state_d;
  logic [NB_ADDR-1:0] pc_q, pc_d;
  logic [CW-1:0]      drop_q, drop_d;

  logic [CW-1:0]      buf_count, buf_unfilled, alloc_count;
  logic               buf_head_valid;
  logic [NB_ADDR-1:0] buf_head_pc;
  logic [NB_WORD-1:0] buf_head_instr;

  logic redirect, misaligned, fire, drop_resp, fill, pop;

  always_comb begin
    // Everything combinational stays quiet while reset is asserted.
    redirect    = i_reset & i_redirect;
    misaligned  = redirect & is_misaligned(i_redirect_addr[1:0]);
    // Stale responses still owed hold credits so they always have a home.
    alloc_count = buf_count + drop_q;

    o_imem_req  = i_reset && (state_q != BOOT) && !i_redirect &&
                  (alloc_count < CREDITS);
    o_imem_addr = pc_q;
    fire        = o_imem_req & i_imem_gnt;

    drop_resp   = i_imem_rvalid && (drop_q != '0);
    fill        = i_imem_rvalid && !drop_resp && !redirect;

    o_instr_valid = i_reset & buf_head_valid;
    o_instr       = buf_head_instr;
    o_instr_pc    = buf_head_pc;
    pop           = o_instr_valid & i_instr_ready & !redirect;

    o_flush          = redirect;
    o_exc_misaligned = misaligned;
    o_exc_addr       = misaligned ? i_redirect_addr : '0;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;

    if (redirect) begin
      // Every old-path request still owed a response becomes a drop. A
      // response arriving this same cycle is one of those (either a pending
      // drop or an unfilled slot), so it always retires one.
      drop_d  = drop_q + buf_unfilled - CW'(i_imem_rvalid);
      pc_d    = misaligned ? TRAP_VECTOR : i_redirect_addr;
      state_d = (drop_d != '0) ? DRAIN : RUN;
    end else begin
      drop_d = drop_q - CW'(drop_resp);
      if (fire) begin
        pc_d = pc_q + NB_ADDR'(4);
      end
      unique case (state_q)
        BOOT:    state_d = RUN;
        DRAIN:   if (drop_d == '0) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  fetch_buffer #(
    .NB_ADDR (NB_ADDR),
    .NB_WORD (NB_WORD),
    .MAX_OUT (MAX_OUT)
  ) u_buffer (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_alloc      (fire),
    .i_alloc_pc   (pc_q),
    .i_fill       (fill),
    .i_fill_data  (i_imem_rdata),
    .i_pop        (pop),
    .i_clear      (redirect),
    .o_count      (buf_count),
    .o_unfilled   (buf_unfilled),
    .o_head_valid (buf_head_valid),
    .o_head_pc    (buf_head_pc),
    .o_head_instr (buf_head_instr)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int unsigned MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP     = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst_n, redir, gnt, rvalid, ready;
  logic [31:0] raddr, rdata;
  logic        flush, exc, req, ivalid;
  logic [31:0] exc_addr, addr, instr, ipc;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .NB_ADDR     (32),
    .NB_WORD     (32),
    .RESET_PC    (RESET_PC),
    .TRAP_VECTOR (TRAP),
    .MAX_OUT     (MAX_OUT)
  ) dut (
    .i_clock          (clk),
    .i_reset          (rst_n),
    .i_redirect       (redir),
    .i_redirect_addr  (raddr),
    .o_flush          (flush),
    .o_exc_misaligned (exc),
    .o_exc_addr       (exc_addr),
    .o_imem_req       (req),
    .o_imem_addr      (addr),
    .i_imem_gnt       (gnt),
    .i_imem_rvalid    (rvalid),
    .i_imem_rdata     (rdata),
    .o_instr_valid    (ivalid),
    .o_instr          (instr),
    .o_instr_pc       (ipc),
    .i_instr_ready    (ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst_n, redir; logic [31:0] raddr; bit gnt, rvalid; logic [31:0] rdata; bit ready;
    bit x_req; logic [31:0] x_addr; bit x_valid; logic [31:0] x_pc, x_instr;
    bit x_flush, x_exc; logic [31:0] x_excaddr;
  } vec_t;

  function automatic vec_t v(bit r, bit rd, logic [31:0] ra, bit g, bit rv, logic [31:0] d,
                             bit rdy, bit xr, logic [31:0] xa, bit xv, logic [31:0] xp,
                             logic [31:0] xi, bit xf, bit xe, logic [31:0] xea);
    vec_t t;
    t.rst_n = r; t.redir = rd; t.raddr = ra; t.gnt = g; t.rvalid = rv; t.rdata = d;
    t.ready = rdy; t.x_req = xr; t.x_addr = xa; t.x_valid = xv; t.x_pc = xp;
    t.x_instr = xi; t.x_flush = xf; t.x_exc = xe; t.x_excaddr = xea;
    return t;
  endfunction

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] instr; bit filled; } ment_t;
  typedef struct { logic [31:0] data; int unsigned due; } resp_t;

  ment_t       mq[$];      // slots in request order
  resp_t       memq[$];    // memory responses owed, in order
  int          m_drop = 0; // old-path responses still to be discarded
  logic [31:0] m_pc = RESET_PC;
  bit          m_booted = 0;
  int unsigned cyc = 0;
  int unsigned lat_lo = 0, lat_hi = 0;

  bit          e_req, e_valid, e_flush, e_exc;
  logic [31:0] e_addr, e_instr, e_ipc, e_excaddr;
  bit          c_rst_n, c_redir, c_gnt, c_ready, c_rvalid;
  logic [31:0] c_raddr, c_rdata;

  task automatic apply(input bit r, input bit rd, input logic [31:0] ra, input bit g, input bit rdy);
    c_rst_n = r; c_redir = rd; c_raddr = ra; c_gnt = g; c_ready = rdy;
    c_rvalid = 1'b0;
    c_rdata  = $urandom();
    if (r && memq.size() > 0 && memq[0].due <= cyc) begin
      c_rvalid = 1'b1;
      c_rdata  = memq[0].data;
      void'(memq.pop_front());
    end
    rst_n = r; redir = rd; raddr = ra; gnt = g; ready = rdy;
    rvalid = c_rvalid; rdata = c_rdata;

    e_req     = r && m_booted && !rd && (mq.size() + m_drop < MAX_OUT);
    e_addr    = m_pc;
    e_valid   = r && mq.size() > 0 && mq[0].filled;
    e_instr   = e_valid ? mq[0].instr : 32'h0;
    e_ipc     = e_valid ? mq[0].pc : 32'h0;
    e_flush   = r && rd;
    e_exc     = e_flush && (ra[1:0] != 2'b00);
    e_excaddr = e_exc ? ra : 32'h0;

    #2;
    check("req", req, e_req);
    if (e_req) check("addr", addr, e_addr);
    check("valid", ivalid, e_valid);
    if (e_valid) begin
      check("instr", instr, e_instr);
      check("instr_pc", ipc, e_ipc);
    end
    check("flush", flush, e_flush);
    check("exc", exc, e_exc);
    check("exc_addr", exc_addr, e_excaddr);
  endtask

  task automatic advance();
    if (!c_rst_n) begin
      mq.delete(); memq.delete();
      m_drop = 0; m_pc = RESET_PC; m_booted = 0;
    end else begin
      if (e_req && c_gnt) begin
        resp_t rs;
        rs.data = $urandom();
        rs.due  = cyc + 1 + $urandom_range(lat_hi, lat_lo);
        if (memq.size() > 0 && memq[$].due > rs.due) rs.due = memq[$].due;
        memq.push_back(rs);
      end
      if (c_redir) begin
        int stale = m_drop;
        foreach (mq[i]) if (!mq[i].filled) stale++;
        if (c_rvalid) stale--;
        m_drop = stale;
        mq.delete();
        m_pc = (c_raddr[1:0] == 2'b00) ? c_raddr : TRAP;
      end else begin
        if (c_rvalid) begin
          if (m_drop > 0) m_drop--;
          else begin
            for (int i = 0; i < mq.size(); i++) begin
              if (!mq[i].filled) begin
                mq[i].instr = c_rdata; mq[i].filled = 1; break;
              end
            end
          end
        end
        if (e_valid && c_ready) void'(mq.pop_front());
        if (e_req && c_gnt) begin
          ment_t ne;
          ne.pc = m_pc; ne.instr = 32'h0; ne.filled = 0;
          mq.push_back(ne);
          m_pc = m_pc + 32'd4;
        end
      end
      m_booted = 1;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    vec_t vt[15];
    localparam logic [31:0] D0 = 32'h1111_0000, D1 = 32'h2222_0004, D2 = 32'h3333_0008;
    localparam logic [31:0] D3 = 32'h4444_000C, D4 = 32'h5555_0010, D5 = 32'h6666_0010;

    rst_n = 0; redir = 0; raddr = 0; gnt = 0; rvalid = 0; rdata = 0; ready = 0;
    @(posedge clk); #1;

    //          rst rd raddr      g rv rdata rdy  req addr     v  pc       instr fl ex exaddr
    vt[0]  = v(0, 0, 32'h0,     0, 0, 32'h0, 0,  0, 32'h0,   0, 32'h0,   32'h0, 0, 0, 32'h0);
    vt[1]  = v(1, 0, 32'h0,     1, 0, 32'h0, 1,  0, 32'h0,   0, 32'h0,   32'h0, 0, 0, 32'h0);
    vt[2]  = v(1, 0, 32'h0,     1, 0, 32'h0, 1,  1, 32'h0,   0, 32'h0,   32'h0, 0, 0, 32'h0);
    vt[3]  = v(1, 0, 32'h0,     1, 1, D0,    1,  1, 32'h4,   0, 32'h0,   32'h0, 0, 0, 32'h0);
    vt[4]  = v(1, 0, 32'h0,     1, 1, D1,    1,  0, 32'h0,   1, 32'h0,   D0,    0, 0, 32'h0);
    vt[5]  = v(1, 0, 32'h0,     1, 0, 32'h0, 1,  1, 32'h8,   1, 32'h4,   D1,    0, 0, 32'h0);
    vt[6]  = v(1, 0, 32'h0,     1, 1, D2,    1,  1, 32'hC,   0, 32'h0,   32'h0, 0, 0, 32'h0);
    vt[7]  = v(1, 0, 32'h0,     1, 1, D3,    0,  0, 32'h0,   1, 32'h8,   D2,    0, 0, 32'h0);
    vt[8]  = v(1, 0, 32'h0,     1, 0, 32'h0, 0,  0, 32'h0,   1, 32'h8,   D2,    0, 0, 32'h0);
    vt[9]  = v(1, 0, 32'h0,     1, 0, 32'h0, 1,  0, 32'h0,   1, 32'h8,   D2,    0, 0, 32'h0);
    vt[10] = v(1, 0, 32'h0,     1, 0, 32'h0, 0,  1, 32'h10,  1, 32'hC,   D3,    0, 0, 32'h0);
    vt[11] = v(1, 1, 32'h102,   1, 0, 32'h0, 0,  0, 32'h0,   1, 32'hC,   D3,    1, 1, 32'h102);
    vt[12] = v(1, 0, 32'h0,     1, 1, D4,    1,  1, 32'h10,  0, 32'h0,   32'h0, 0, 0, 32'h0);
    vt[13] = v(1, 0, 32'h0,     0, 1, D5,    1,  1, 32'h14,  0, 32'h0,   32'h0, 0, 0, 32'h0);
    vt[14] = v(1, 0, 32'h0,     0, 0, 32'h0, 1,  1, 32'h14,  1, 32'h10,  D5,    0, 0, 32'h0);

    for (int i = 0; i < 15; i++) begin
      rst_n = vt[i].rst_n; redir = vt[i].redir; raddr = vt[i].raddr; gnt = vt[i].gnt;
      rvalid = vt[i].rvalid; rdata = vt[i].rdata; ready = vt[i].ready;
      #2;
      check($sformatf("vec%0d_req", i), req, vt[i].x_req);
      if (vt[i].x_req) check($sformatf("vec%0d_addr", i), addr, vt[i].x_addr);
      check($sformatf("vec%0d_valid", i), ivalid, vt[i].x_valid);
      if (vt[i].x_valid) begin
        check($sformatf("vec%0d_pc", i), ipc, vt[i].x_pc);
        check($sformatf("vec%0d_instr", i), instr, vt[i].x_instr);
      end
      check($sformatf("vec%0d_flush", i), flush, vt[i].x_flush);
      check($sformatf("vec%0d_exc", i), exc, vt[i].x_exc);
      check($sformatf("vec%0d_exc_addr", i), exc_addr, vt[i].x_excaddr);
      @(posedge clk); #1;
    end

    // A: redirect with two requests unfilled; both old responses are dropped
    lat_lo = 2; lat_hi = 2;
    apply(0, 0, 0, 0, 0); advance();
    apply(1, 0, 0, 1, 1); advance();
    apply(1, 0, 0, 1, 1); advance();
    apply(1, 0, 0, 1, 1); advance();
    apply(1, 1, 32'h100, 1, 1); check("a_flush", flush, 1); advance();
    repeat (8) begin apply(1, 0, 0, 1, 0); advance(); end
    apply(1, 0, 0, 0, 0);
    check("a_head_valid", ivalid, 1);
    check("a_head_pc", ipc, 32'h100);
    advance();

    // B: redirect coinciding with an old response and a decode pop
    lat_lo = 0; lat_hi = 0;
    apply(0, 0, 0, 0, 0); advance();
    apply(1, 0, 0, 1, 1); advance();
    apply(1, 0, 0, 1, 1); advance();
    apply(1, 0, 0, 1, 1); advance();
    apply(1, 1, 32'h200, 1, 1); check("b_rvalid_present", rvalid, 1); advance();
    apply(1, 0, 0, 1, 1);
    check("b_valid_after", ivalid, 0);
    check("b_req_after", req, 1);
    check("b_addr_after", addr, 32'h200);
    advance();

    // C: PC wrap at the top of the address space
    apply(1, 1, 32'hFFFF_FFFC, 1, 1); advance();
    apply(1, 0, 0, 1, 1); check("c_addr_top", addr, 32'hFFFF_FFFC); advance();
    apply(1, 0, 0, 1, 1);
    check("c_wrap_req", req, 1);
    check("c_wrap_addr", addr, 32'h0);
    advance();

    // D: reset while draining stale responses
    lat_lo = 2; lat_hi = 2;
    apply(0, 0, 0, 0, 0); advance();
    apply(1, 0, 0, 1, 1); advance();
    apply(1, 0, 0, 1, 1); advance();
    apply(1, 0, 0, 1, 1); advance();
    apply(1, 1, 32'h300, 1, 1); advance();
    apply(0, 1, 32'h303, 1, 1);
    check("d_rst_req", req, 0);
    check("d_rst_flush", flush, 0);
    check("d_rst_exc", exc, 0);
    check("d_rst_exc_addr", exc_addr, 0);
    advance();
    apply(1, 0, 0, 1, 1); check("d_boot_req", req, 0); check("d_boot_valid", ivalid, 0); advance();
    apply(1, 0, 0, 1, 1); check("d_first_req", req, 1); check("d_first_addr", addr, RESET_PC); advance();

    // Randomized traffic against the model
    lat_lo = 2; lat_hi = 0;
    apply(0, 0, 0, 0, 0); advance();
    for (int n = 0; n < 3000; n++) begin
      bit          r, rd, g, rdy;
      logic [31:0] ra;
      r   = ($urandom_range(0, 399) != 0);
      rd  = ($urandom_range(0, 15) == 0);
      g   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 7);
      ra  = $urandom();
      ra[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      apply(r, rd, ra, g, rdy);
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
